simd_neg_pipe: RTL
==================

# simd_neg_pipe

Pipelined, partitioned two's-complement unit for the vector lane. It performs bitwise NOT, negate, absolute value and saturating absolute value on packed elements of selectable width. It generalises the lane's combinational SIMD invert/increment path with an op select, per-element overflow flags, a two-stage register pipeline and a valid/ready handshake. It sits between the lane operand read and the lane writeback arbiter.

## Interface
- `MIN_WIDTH`, 8, narrowest element width and lane granule in bits
- `MAX_WIDTH`, 64, datapath width in bits
- `RATIO`, MAX_WIDTH/MIN_WIDTH, number of granules (derived)
- `SEW_WIDTH`, $clog2(RATIO)+1, element-width select bits (derived)
- `TAG_WIDTH`, 4, opaque sideband carried alongside each transaction
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `valid_i`  in  1  input transaction valid
- `ready_o`  out  1  unit accepts input this cycle
- `op_i`  in  2  00 NOT, 01 NEG, 10 ABS, 11 ABS_SAT
- `sew_i`  in  SEW_WIDTH  one-hot element width; bit k selects MAX_WIDTH>>k
- `enable_i`  in  RATIO  per-granule mask
- `opA_i`  in  MAX_WIDTH  packed operand
- `tag_i`  in  TAG_WIDTH  sideband
- `valid_o`  out  1  result valid
- `ready_i`  in  1  consumer accepts result
- `result_o`  out  MAX_WIDTH  packed result
- `ovf_o`  out  RATIO  per-granule overflow; all granules of a flagged element are set
- `tag_o`  out  TAG_WIDTH  sideband of the result

## Operation
- Element enable is the `enable_i` bit of the element's most-significant granule. Disabled elements pass `opA` through unchanged with ovf 0.
- Illegal `sew_i` values:
  - Not one-hot: the highest set bit (narrowest width) wins.
  - All-zero: treated as MAX_WIDTH.
- NOT: invert all bits of the element; ovf 0.
- NEG: ~x+1 modulo the element width. ovf=1 iff x is the most negative value; the result is then x.
- ABS: if the element sign bit is 1, same as NEG; otherwise pass through. ovf as for NEG.
- ABS_SAT: as ABS, but the most negative input yields max positive (0x7F…F) with ovf=1.
- Carries never cross an element boundary. The increment carry enters only at the element's least-significant granule.
- Stage 1 (S1) registers:
  - inverted data
  - per-element invert bit
  - per-granule all-ones propagate bits
  - most-negative detect
  - op, tag
- Stage 2 (S2) registers:
  - segmented prefix of the propagate bits producing per-granule carry-in
  - increment
  - saturation substitution
  - ovf, result

## Timing
- Latency: 2 cycles from accept (`valid_i && ready_o`) to `valid_o`.
- Throughput: 1 per cycle when `ready_i` is high.
- S2 advances when `!s2_valid || ready_i`.
- S1 advances when `!s1_valid || s2 advances`.
- `ready_o` = S1 advances. It is combinational from `ready_i`; there is no skid buffer.
- While `valid_o && !ready_i`, `result_o`, `ovf_o` and `tag_o` hold stable.
- Results leave strictly in acceptance order. Simultaneous accept and emit in one cycle is legal.
- Reset (synchronous, any cycle including mid-stall):
  - Both stage valids clear.
  - Next cycle: `valid_o`=0, `ready_o`=1, `result_o`=0, `ovf_o`=0, `tag_o`=0.
  - In-flight transactions are discarded.
- `ready_o` is ignored while `rst` is high; inputs presented during reset are dropped.

## Structure
- Package `simd_neg_pkg`:
  - `op_e` enum (NOT/NEG/ABS/ABS_SAT)
  - `sew_decode` function (one-hot to boundary mask, priority rule above)
  - `elem_msb_mask` function
- S1 reuses the existing `simd_inv` for the mask-and-invert step.
- One new sub-module, `simd_seg_prefix_inc`, is combinational. It takes the boundary mask, per-granule propagate bits and carry-ins, and produces incremented data. It lives in S2.
- Handshake and registers stay in the top.

## Test plan
- sew_i=4'b1000, NEG, enable 8'hFF, opA 0x0102030405060780 → result 0xFFFEFDFCFBFAF980, ovf_o 8'h01.
- sew_i=4'b0001, NEG, opA 0x0000000000000001 → 0xFFFFFFFFFFFFFFFF, ovf 0. Then opA 0 → 0, ovf 0.
- sew_i=4'b0100, ABS_SAT, opA 0x8000FFFF7FFF0005 → 0x7FFF00017FFF0005, ovf_o 8'hC0.
- sew_i=4'b0010, NEG, enable 8'h0F, opA 0x0000000100000001 → 0x00000001FFFFFFFF.
- Backpressure:
  - Stimulus: 3 back-to-back inputs with tags 1,2,3; `ready_i` low for 4 cycles.
  - `ready_o` drops once both stages are full.
  - Outputs are stable while stalled.
  - Tags emerge 1,2,3 with none lost or duplicated.
- Reset mid-op:
  - Stimulus: `rst` pulsed with S1 and S2 both valid.
  - Next cycle `valid_o`=0, `result_o`=0, `ready_o`=1.
  - The first post-reset input emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/simd_neg_pkg.sv
// Shared types and element-geometry helpers for the partitioned two's-complement unit.
// Granule masks are sized for the widest supported lane; callers truncate to their RATIO.
package simd_neg_pkg;

  typedef enum logic [1:0] {
    OP_NOT     = 2'b00,
    OP_NEG     = 2'b01,
    OP_ABS     = 2'b10,
    OP_ABS_SAT = 2'b11
  } op_e;

  localparam int MAX_GRANULES = 64;

  // One-hot width select to a mask of element least-significant granules.
  // The highest set bit (narrowest element) wins; all-zero means one full-width element.
  function automatic logic [MAX_GRANULES-1:0] sew_decode(input logic [7:0] sew, input int ratio);
    logic [MAX_GRANULES-1:0] m;
    int k;
    int n;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (sew[i]) k = i;
    n = ratio >> k;
    if (n < 1) n = 1;
    m = '0;
    for (int g = 0; g < MAX_GRANULES; g++)
      if (g < ratio && (g & (n - 1)) == 0) m[g] = 1'b1;
    return m;
  endfunction

  // Element most-significant granules: the top granule, or any granule whose upper neighbour starts an element.
  function automatic logic [MAX_GRANULES-1:0] elem_msb_mask(input logic [MAX_GRANULES-1:0] lsb, input int ratio);
    logic [MAX_GRANULES-1:0] m;
    m = '0;
    for (int g = 0; g < MAX_GRANULES; g++) begin
      if (g == ratio - 1) m[g] = 1'b1;
      else if (g < ratio - 1) m[g] = lsb[g + 1];
    end
    return m;
  endfunction

endpackage

// File: rtl/simd_inv.sv
// Granule-masked bitwise invert: each granule is inverted when its mask bit is set.
module simd_inv #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int RATIO     = MAX_WIDTH / MIN_WIDTH
) (
  input  logic [RATIO-1:0]     mask_i,
  input  logic [MAX_WIDTH-1:0] data_i,
  output logic [MAX_WIDTH-1:0] data_o
);

  for (genvar g = 0; g < RATIO; g++) begin : g_gran
    assign data_o[g*MIN_WIDTH +: MIN_WIDTH] = data_i[g*MIN_WIDTH +: MIN_WIDTH] ^ {MIN_WIDTH{mask_i[g]}};
  end

endmodule

// File: rtl/simd_seg_prefix_inc.sv
// Segmented increment: carry enters at each element's low granule and ripples only
// through all-ones granules of the same element.
module simd_seg_prefix_inc #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int RATIO     = MAX_WIDTH / MIN_WIDTH
) (
  input  logic [RATIO-1:0]     bnd_i,
  input  logic [RATIO-1:0]     prop_i,
  input  logic [RATIO-1:0]     cin_i,
  input  logic [MAX_WIDTH-1:0] data_i,
  output logic [MAX_WIDTH-1:0] data_o
);

  logic [RATIO-1:0] carry;

  always_comb begin : prefix
    logic c;
    carry = '0;
    c     = 1'b0;
    for (int g = 0; g < RATIO; g++) begin
      if (bnd_i[g]) c = cin_i[g];
      carry[g] = c;
      c        = c & prop_i[g];
    end
  end

  for (genvar g = 0; g < RATIO; g++) begin : g_gran
    assign data_o[g*MIN_WIDTH +: MIN_WIDTH] =
      data_i[g*MIN_WIDTH +: MIN_WIDTH] + {{(MIN_WIDTH-1){1'b0}}, carry[g]};
  end

endmodule

// File: rtl/simd_neg_pipe.sv
// Two-stage partitioned NOT/NEG/ABS/ABS_SAT unit with valid/ready handshake.
// S1 inverts and classifies elements; S2 does the segmented increment and saturation.
module simd_neg_pipe
  import simd_neg_pkg::*;
#(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int RATIO     = MAX_WIDTH / MIN_WIDTH,
  parameter int SEW_WIDTH = $clog2(RATIO) + 1,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           op_i,
  input  logic [SEW_WIDTH-1:0] sew_i,
  input  logic [RATIO-1:0]     enable_i,
  input  logic [MAX_WIDTH-1:0] opA_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [MAX_WIDTH-1:0] result_o,
  output logic [RATIO-1:0]     ovf_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam int W      = MIN_WIDTH;
  localparam int STAGES = 2;

  logic              s1_adv, s2_adv;
  logic [STAGES:1]   vld_pipe_d, vld_pipe_q;

  logic [RATIO-1:0]     bnd, msb, elem_en, elem_sign, elem_mn, inv, prop, flag;
  logic [MAX_WIDTH-1:0] inv_data;

  logic [MAX_WIDTH-1:0] s1_data_d, s1_data_q;
  logic [RATIO-1:0]     s1_inv_d, s1_inv_q, s1_prop_d, s1_prop_q;
  logic [RATIO-1:0]     s1_mn_d, s1_mn_q, s1_bnd_d, s1_bnd_q;
  op_e                  s1_op_d, s1_op_q;
  logic [TAG_WIDTH-1:0] s1_tag_d, s1_tag_q;

  logic [RATIO-1:0]     inc;
  logic [MAX_WIDTH-1:0] inc_data, s2_res;
  logic [MAX_WIDTH-1:0] result_d, result_q;
  logic [RATIO-1:0]     ovf_d, ovf_q;
  logic [TAG_WIDTH-1:0] tag_d, tag_q;

  assign s2_adv  = !vld_pipe_q[2] || ready_i;
  assign s1_adv  = !vld_pipe_q[1] || s2_adv;
  assign ready_o = s1_adv;

  assign bnd = RATIO'(sew_decode(8'(sew_i), RATIO));
  assign msb = RATIO'(elem_msb_mask(64'(bnd), RATIO));

  // Per-element attributes live at the top granule; broadcast them down over the element.
  always_comb begin : s1_decode
    logic en_c, sign_c, mn_c, zlo_c;
    logic [RATIO-1:0] mn_at;
    elem_en   = '0;
    elem_sign = '0;
    elem_mn   = '0;
    mn_at     = '0;
    en_c      = 1'b0;
    sign_c    = 1'b0;
    mn_c      = 1'b0;
    zlo_c     = 1'b0;
    for (int g = 0; g < RATIO; g++) begin
      if (bnd[g]) zlo_c = 1'b1;
      mn_at[g] = zlo_c && (opA_i[g*W +: W] == {1'b1, {(W-1){1'b0}}});
      zlo_c    = zlo_c && (opA_i[g*W +: W] == '0);
    end
    for (int g = RATIO - 1; g >= 0; g--) begin
      if (msb[g]) begin
        en_c   = enable_i[g];
        sign_c = opA_i[g*W + W - 1];
        mn_c   = mn_at[g];
      end
      elem_en[g]   = en_c;
      elem_sign[g] = sign_c;
      elem_mn[g]   = mn_c;
    end
  end

  always_comb begin
    inv  = '0;
    flag = '0;
    for (int g = 0; g < RATIO; g++) begin
      inv[g]  = elem_en[g] && (op_e'(op_i) == OP_NOT || op_e'(op_i) == OP_NEG || elem_sign[g]);
      flag[g] = elem_en[g] && op_e'(op_i) != OP_NOT && elem_mn[g];
    end
  end

  simd_inv #(.MIN_WIDTH(MIN_WIDTH), .MAX_WIDTH(MAX_WIDTH), .RATIO(RATIO)) u_inv (
    .mask_i (inv),
    .data_i (opA_i),
    .data_o (inv_data)
  );

  always_comb begin
    prop = '0;
    for (int g = 0; g < RATIO; g++) prop[g] = &inv_data[g*W +: W];
  end

  // S2 datapath: NOT never increments; most-negative ABS_SAT keeps the inverted 0x7F..F.
  assign inc = s1_inv_q & {RATIO{s1_op_q != OP_NOT}};

  simd_seg_prefix_inc #(.MIN_WIDTH(MIN_WIDTH), .MAX_WIDTH(MAX_WIDTH), .RATIO(RATIO)) u_inc (
    .bnd_i  (s1_bnd_q),
    .prop_i (s1_prop_q),
    .cin_i  (inc),
    .data_i (s1_data_q),
    .data_o (inc_data)
  );

  always_comb begin
    s2_res = '0;
    for (int g = 0; g < RATIO; g++)
      s2_res[g*W +: W] = (s1_op_q == OP_ABS_SAT && s1_mn_q[g]) ? s1_data_q[g*W +: W] : inc_data[g*W +: W];
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_data_d  = s1_data_q;
    s1_inv_d   = s1_inv_q;
    s1_prop_d  = s1_prop_q;
    s1_mn_d    = s1_mn_q;
    s1_bnd_d   = s1_bnd_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    tag_d      = tag_q;
    if (s1_adv) vld_pipe_d[1] = valid_i;
    if (s1_adv && valid_i) begin
      s1_data_d = inv_data;
      s1_inv_d  = inv;
      s1_prop_d = prop;
      s1_mn_d   = flag;
      s1_bnd_d  = bnd;
      s1_op_d   = op_e'(op_i);
      s1_tag_d  = tag_i;
    end
    if (s2_adv) vld_pipe_d[2] = vld_pipe_q[1];
    // Outputs only change on a real S1->S2 transfer, so they hold through stalls and bubbles.
    if (s2_adv && vld_pipe_q[1]) begin
      result_d = s2_res;
      ovf_d    = s1_mn_q;
      tag_d    = s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_data_q  <= '0;
      s1_inv_q   <= '0;
      s1_prop_q  <= '0;
      s1_mn_q    <= '0;
      s1_bnd_q   <= '0;
      s1_op_q    <= OP_NOT;
      s1_tag_q   <= '0;
      result_q   <= '0;
      ovf_q      <= '0;
      tag_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_data_q  <= s1_data_d;
      s1_inv_q   <= s1_inv_d;
      s1_prop_q  <= s1_prop_d;
      s1_mn_q    <= s1_mn_d;
      s1_bnd_q   <= s1_bnd_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      tag_q      <= tag_d;
    end
  end

  assign valid_o  = vld_pipe_q[2];
  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign tag_o    = tag_q;

endmodule
